// File: rtl/niosii_mult_pkg.sv
// Shared types for the sequential Nios II multiplier: mode encodings,
// FSM state enum and the per-mode operand signedness helper.
package niosii_mult_pkg;

  localparam int unsigned MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_MUL    = 2'b00;
  localparam mode_t MODE_MULXUU = 2'b01;
  localparam mode_t MODE_MULXSS = 2'b10;
  localparam mode_t MODE_MULXSU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic s1_signed;
    logic s2_signed;
  } sign_flags_t;

  // Which operands are interpreted as two's complement for a given mode
  function automatic sign_flags_t mode_signs(input mode_t m);
    sign_flags_t f;
    f.s1_signed = (m == MODE_MULXSS) || (m == MODE_MULXSU);
    f.s2_signed = (m == MODE_MULXSS);
    return f;
  endfunction

endpackage

// File: rtl/niosii_mult_slice.sv
// Combinational SLICE_W x SLICE_W unsigned multiply, mapped onto one DSP block.
(* use_dsp = "yes" *)
module niosii_mult_slice #(
  parameter int unsigned SLICE_W = 16
) (
  input  logic [SLICE_W-1:0]   a,
  input  logic [SLICE_W-1:0]   b,
  output logic [2*SLICE_W-1:0] p
);

  // Full-width unsigned product
  assign p = (2*SLICE_W)'(a) * (2*SLICE_W)'(b);

endmodule

// File: rtl/niosii_system_cpu_mult_seq.sv
// Iterative multiplier: one slice product per cycle accumulated into a
// 2*DATA_W product, sign applied at the end, selected word returned.
// Optional build macro NIOS_MULT_ZERO_BYPASS_EN: zero operands skip ACC/FIX.
module niosii_system_cpu_mult_seq #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SLICE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result
);

  import niosii_mult_pkg::*;

  localparam int unsigned NSL   = DATA_W / SLICE_W;
  localparam int unsigned P     = NSL * NSL;
  localparam int unsigned ACC_W = 2 * DATA_W;
  localparam int unsigned CNT_W = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned IDX_W = (NSL > 1) ? $clog2(NSL) : 1;

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              neg_q, neg_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic [IDX_W-1:0]     a_idx, b_idx;
  logic [SLICE_W-1:0]   a_slice, b_slice;
  logic [2*SLICE_W-1:0] prod;
  logic [ACC_W-1:0]     acc_fix;
  sign_flags_t          flags;

  // Slice selection for the current partial product
  always_comb begin
    a_idx   = IDX_W'(cnt_q % CNT_W'(NSL));
    b_idx   = IDX_W'(cnt_q / CNT_W'(NSL));
    a_slice = a_q[a_idx*SLICE_W +: SLICE_W];
    b_slice = b_q[b_idx*SLICE_W +: SLICE_W];
  end

  niosii_mult_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a (a_slice),
    .b (b_slice),
    .p (prod)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    a_d         = a_q;
    b_d         = b_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags       = mode_signs(mode);
    acc_fix     = neg_q ? -acc_q : acc_q;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          mode_d     = mode;
          a_d        = (flags.s1_signed && src1[DATA_W-1]) ? -src1 : src1;
          b_d        = (flags.s2_signed && src2[DATA_W-1]) ? -src2 : src2;
          neg_d      = (flags.s1_signed & src1[DATA_W-1]) ^
                       (flags.s2_signed & src2[DATA_W-1]);
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ACC;
`ifdef NIOS_MULT_ZERO_BYPASS_EN
          if ((src1 == '0) || (src2 == '0)) begin
            neg_d       = 1'b0;
            result_d    = '0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
`endif
        end
      end
      ACC: begin
        acc_d = acc_q + (ACC_W'(prod) << (SLICE_W * (32'(a_idx) + 32'(b_idx))));
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(P - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        acc_d       = acc_fix;
        result_d    = (mode_q == MODE_MUL) ? acc_fix[DATA_W-1:0] : acc_fix[ACC_W-1:DATA_W];
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= MODE_MUL;
      a_q         <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
